// File: rtl/jmp_seq_fsm_if.sv
// jmp_seq_fsm_if
// Bundles the go/jmp control strobes and the sequencer status outputs of
// jmp_seq_fsm so they can be passed as one port.
//   master : drives go, jmp, hold, abort, clr_cnt; observes the status
//   slave  : the sequencer; observes the strobes, drives state, y1, busy,
//            done, wrap_cnt
// SW must equal $clog2(NUM_STATES) of the connected sequencer, and CNT_W must
// equal its CNT_W.
interface jmp_seq_fsm_if #(
    parameter int unsigned SW    = 4,
    parameter int unsigned CNT_W = 8
);
    logic             go;
    logic             jmp;
    logic             hold;
    logic             abort;
    logic             clr_cnt;
    logic [SW-1:0]    state;
    logic             y1;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] wrap_cnt;

    modport master (
        output go, jmp, hold, abort, clr_cnt,
        input  state, y1, busy, done, wrap_cnt
    );

    modport slave (
        input  go, jmp, hold, abort, clr_cnt,
        output state, y1, busy, done, wrap_cnt
    );
endinterface

// File: rtl/jmp_seq_fsm.sv
// jmp_seq_fsm
// Linear step sequencer S0..S(NUM_STATES-1) started by go, with a jump to
// JMP_TARGET, hold, abort, a one-cycle completion pulse and a saturating
// count of completed passes.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : jmp_seq_fsm_if.slave
//          in  go, jmp, hold, abort, clr_cnt
//          out state (registered index), y1 (state == JMP_TARGET),
//              busy (state != 0), done (completion pulse),
//              wrap_cnt (saturating pass count)
module jmp_seq_fsm #(
    parameter int unsigned NUM_STATES = 10,
    parameter int unsigned JMP_TARGET = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst,
    jmp_seq_fsm_if.slave  bus
);
    localparam int unsigned SW = $clog2(NUM_STATES);

    localparam logic [SW-1:0] LAST_ST   = SW'(NUM_STATES - 1);
    localparam logic [SW-1:0] TARGET_ST = SW'(JMP_TARGET);

    // The state itself is a parametrised chain index, so the enum names the
    // kind of transition taken rather than the states.
    typedef enum logic [1:0] {
        ACT_STAY,
        ACT_ZERO,
        ACT_JUMP,
        ACT_ADV
    } act_e;

    act_e             act;
    logic             wrap;
    logic [SW-1:0]    state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        act     = ACT_STAY;
        state_d = state_q;
        wrap    = 1'b0;
        done_d  = 1'b0;
        cnt_d   = cnt_q;

        if (bus.abort) begin
            act = ACT_ZERO;
        end else if (state_q == '0) begin
            // hold has no meaning before the sequence has started
            if (bus.go) begin
                act = bus.jmp ? ACT_JUMP : ACT_ADV;
            end
        end else if (bus.hold) begin
            act = ACT_STAY;
        end else if (bus.jmp) begin
            act = ACT_JUMP;
        end else begin
            act = ACT_ADV;
        end

        unique case (act)
            ACT_STAY: state_d = state_q;
            ACT_ZERO: state_d = '0;
            ACT_JUMP: state_d = TARGET_ST;
            ACT_ADV: begin
                if (state_q == LAST_ST) begin
                    state_d = '0;
                    wrap    = 1'b1;
                end else begin
                    state_d = state_q + 1'b1;
                end
            end
            default: state_d = state_q;
        endcase

        // Only a plain advance out of the last state is a completed pass.
        done_d = wrap;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (wrap && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.y1       = (state_q == TARGET_ST);
    assign bus.busy     = (state_q != '0);
    assign bus.done     = done_q;
    assign bus.wrap_cnt = cnt_q;
endmodule

// File: tb/tb_jmp_seq_fsm.sv
// tb_jmp_seq_fsm
// Two sequencers: A with default parameters (10 states, target 3, 8-bit
// count) and B with 4 states, target 2, 2-bit count. A vector table walks
// both through their cycles; a few hand-written sequences follow.
module tb_jmp_seq_fsm;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    jmp_seq_fsm_if #(.SW(4), .CNT_W(8)) bus_a ();
    jmp_seq_fsm_if #(.SW(2), .CNT_W(2)) bus_b ();

    jmp_seq_fsm #(.NUM_STATES(10), .JMP_TARGET(3), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    jmp_seq_fsm #(.NUM_STATES(4), .JMP_TARGET(2), .CNT_W(2)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    typedef struct {
        bit dut;   // 0 = A, 1 = B
        bit rst;
        bit go;
        bit jmp;
        bit hold;
        bit abort;
        bit clr;
        int st;
        bit y1;
        bit busy;
        bit done;
        int cnt;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input bit d, input bit r, input bit g, input bit j,
                       input bit h, input bit a, input bit c,
                       input int st, input bit dn, input int cnt);
        vec_t v;
        int   tgt;
        tgt     = d ? 2 : 3;
        v.dut   = d;
        v.rst   = r;
        v.go    = g;
        v.jmp   = j;
        v.hold  = h;
        v.abort = a;
        v.clr   = c;
        v.st    = st;
        v.y1    = (st == tgt);
        v.busy  = (st != 0);
        v.done  = dn;
        v.cnt   = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_a         = (v.dut == 1'b0) && v.rst;
        bus_a.go      = (v.dut == 1'b0) && v.go;
        bus_a.jmp     = (v.dut == 1'b0) && v.jmp;
        bus_a.hold    = (v.dut == 1'b0) && v.hold;
        bus_a.abort   = (v.dut == 1'b0) && v.abort;
        bus_a.clr_cnt = (v.dut == 1'b0) && v.clr;
        rst_b         = (v.dut == 1'b1) && v.rst;
        bus_b.go      = (v.dut == 1'b1) && v.go;
        bus_b.jmp     = (v.dut == 1'b1) && v.jmp;
        bus_b.hold    = (v.dut == 1'b1) && v.hold;
        bus_b.abort   = (v.dut == 1'b1) && v.abort;
        bus_b.clr_cnt = (v.dut == 1'b1) && v.clr;
    endtask

    task automatic idle_all();
        rst_a = 0; bus_a.go = 0; bus_a.jmp = 0; bus_a.hold = 0; bus_a.abort = 0; bus_a.clr_cnt = 0;
        rst_b = 0; bus_b.go = 0; bus_b.jmp = 0; bus_b.hold = 0; bus_b.abort = 0; bus_b.clr_cnt = 0;
    endtask

    initial begin
        int st, y1, busy, done, cnt, edges, pv;
        bit seen;

        // ---------------- sequencer A (defaults) ----------------
        // reset held for 2 edges, then 3 idle edges
        repeat (2) add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // full pass 1..9 then wrap
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        for (int s = 2; s <= 9; s++) add(0, 0, 0, 0, 0, 0, 0, s, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // go with jmp lands on target; jmp in target stays there
        add(0, 0, 1, 1, 0, 0, 0, 3, 0, 1);
        repeat (3) add(0, 0, 0, 1, 0, 0, 0, 3, 0, 1);
        for (int s = 4; s <= 9; s++) add(0, 0, 0, 0, 0, 0, 0, s, 0, 1);
        // jmp from last state is not a completed pass
        add(0, 0, 0, 1, 0, 0, 0, 3, 0, 1);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        // go while busy has no effect beyond the normal advance
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 2, 0, 1);
        for (int s = 3; s <= 5; s++) add(0, 0, 0, 0, 0, 0, 0, s, 0, 1);
        // hold at 5 for 4 edges, one of them with jmp (hold wins)
        repeat (2) add(0, 0, 0, 0, 1, 0, 0, 5, 0, 1);
        add(0, 0, 0, 1, 1, 0, 0, 5, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 5, 0, 1);
        // abort beats hold; hold ignored in S0
        add(0, 0, 0, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 1, 0, 1, 0, 0, 1, 0, 1);
        for (int s = 2; s <= 7; s++) add(0, 0, 0, 0, 0, 0, 0, s, 0, 1);
        // reset mid-pass at state 7
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ---------------- sequencer B (4 states, target 2, 2-bit count) ----
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int p = 1; p <= 5; p++) begin
            pv = (p - 1 > 3) ? 3 : p - 1;
            add(1, 0, 1, 0, 0, 0, 0, 1, 0, pv);
            add(1, 0, 0, 0, 0, 0, 0, 2, 0, pv);
            add(1, 0, 0, 0, 0, 0, 0, 3, 0, pv);
            add(1, 0, 0, 0, 0, 0, 0, 0, 1, (p > 3) ? 3 : p);
        end
        // clear on the wrap edge: count cleared, done still pulses
        add(1, 0, 1, 0, 0, 0, 0, 1, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 2, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 3, 0, 3);
        add(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        idle_all();
        rst_a = 1; rst_b = 1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            if (vecs[i].dut == 1'b0) begin
                st = int'(bus_a.state); y1 = int'(bus_a.y1); busy = int'(bus_a.busy);
                done = int'(bus_a.done); cnt = int'(bus_a.wrap_cnt);
            end else begin
                st = int'(bus_b.state); y1 = int'(bus_b.y1); busy = int'(bus_b.busy);
                done = int'(bus_b.done); cnt = int'(bus_b.wrap_cnt);
            end
            chk($sformatf("v%0d state", i), st, vecs[i].st);
            chk($sformatf("v%0d y1", i), y1, int'(vecs[i].y1));
            chk($sformatf("v%0d busy", i), busy, int'(vecs[i].busy));
            chk($sformatf("v%0d done", i), done, int'(vecs[i].done));
            chk($sformatf("v%0d wrap_cnt", i), cnt, vecs[i].cnt);
        end

        // ---- Moore outputs: no combinational path from inputs (A in S0) ----
        idle_all();
        bus_a.go = 1; bus_a.jmp = 1;
        #1;
        chk("moore busy before edge", int'(bus_a.busy), 0);
        chk("moore y1 before edge", int'(bus_a.y1), 0);
        @(posedge clk);
        #1;
        chk("go+jmp state", int'(bus_a.state), 3);
        chk("go+jmp y1", int'(bus_a.y1), 1);
        bus_a.go = 0; bus_a.jmp = 0; bus_a.abort = 1;
        #1;
        chk("moore y1 under abort", int'(bus_a.y1), 1);
        @(posedge clk);
        #1;
        chk("abort state", int'(bus_a.state), 0);
        chk("abort done", int'(bus_a.done), 0);
        bus_a.abort = 0;

        // ---- B pass length: NUM_STATES edges from go to done, bounded wait ----
        bus_b.go = 1;
        @(posedge clk);
        #1;
        bus_b.go = 0;
        edges = 1;
        seen  = bus_b.done;
        while (!seen && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            seen = bus_b.done;
        end
        chk("B done seen", int'(seen), 1);
        chk("B pass edges", edges, 4);
        chk("B pass state", int'(bus_b.state), 0);
        chk("B pass wrap_cnt", int'(bus_b.wrap_cnt), 1);
        @(posedge clk);
        #1;
        chk("B done one cycle", int'(bus_b.done), 0);
        chk("B wrap_cnt held", int'(bus_b.wrap_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
